mfp_div_seq: RTL

- Iterative fixed-point divider. It is the inverse operation of the toolbox's combinational fixed-point multiplier.
- Computes quot = (num << FracW) / den, using one restoring-division step per clock.
- Applies the toolbox rounding and saturation conventions to the result.
- Used where SIFT datapaths need normalisation or ratio terms and a full combinational divider is too large; sits between pipeline stages behind valid/ready handshakes.

---
 rtl/mfp_div_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mfp_div_seq.sv
// Sequential restoring fixed-point divider: quot = (num << FracW) / den, one quotient bit per clock,
// with round-half-away / truncate, symmetric saturation or wrap, and divide-by-zero flagging.
module mfp_div_seq #(
  parameter int NumW       = 16,
  parameter int DenW       = NumW,
  parameter int OutW       = NumW,
  parameter int FracW      = 0,
  parameter int isUnsigned = 0,
  parameter int isFloor    = 1,
  parameter int Saturate   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NumW-1:0] num,
  input  logic [DenW-1:0] den,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OutW-1:0] quot,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int IterN = NumW + FracW + ((isFloor != 0) ? 0 : 1);
  localparam int CntW  = $clog2(IterN + 1);
  localparam int QW    = IterN + 1;
  localparam int CW    = ((QW > OutW) ? QW : OutW) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CntW-1:0]   cnt;
  logic              num_neg, den_neg, den_zero;
  logic [IterN-1:0]  dvd, q;
  logic [DenW-1:0]   dmag;
  logic [DenW:0]     rem;

  logic              num_sign, den_sign;
  logic [NumW-1:0]   num_mag;
  logic [DenW-1:0]   den_mag;
  logic [IterN-1:0]  dvd_load;
  logic [DenW:0]     rem_sh;
  logic [DenW+1:0]   trial;
  logic              borrow;

  assign in_ready = (state == IDLE);

  // Magnitudes are unsigned and one bit wider in effect, so the most negative input is exact.
  always_comb begin
    num_sign = (isUnsigned == 0) && num[NumW-1];
    den_sign = (isUnsigned == 0) && den[DenW-1];
    num_mag  = num_sign ? -num : num;
    den_mag  = den_sign ? -den : den;
    dvd_load = '0;
    dvd_load[NumW-1:0] = num_mag;
    dvd_load = dvd_load << (IterN - NumW);
    rem_sh   = (rem << 1) | {{DenW{1'b0}}, dvd[IterN-1]};
    trial    = {1'b0, rem_sh} - {2'b00, dmag};
    borrow   = trial[DenW+1];
  end

  logic [QW-1:0]   mag;
  logic [CW-1:0]   mag_c, max_c;
  logic            res_neg, fix_ovf;
  logic [OutW-1:0] fix_quot;

  // With rounding, q carries one extra LSB below the result; adding it rounds half away from zero.
  always_comb begin
    if (isFloor != 0) mag = {1'b0, q};
    else              mag = {2'b00, q[IterN-1:1]} + {{IterN{1'b0}}, q[0]};
    mag_c = CW'(mag);
    max_c = '0;
    if (isUnsigned != 0) max_c[OutW-1:0] = '1;
    else                 max_c[OutW-2:0] = '1;
    res_neg  = (isUnsigned == 0) && (num_neg ^ den_neg);
    fix_ovf  = 1'b0;
    fix_quot = res_neg ? -mag_c[OutW-1:0] : mag_c[OutW-1:0];
    if (den_zero) begin
      fix_quot = num_neg ? -max_c[OutW-1:0] : max_c[OutW-1:0];
    end else if (mag_c > max_c) begin
      fix_ovf = 1'b1;
      if (Saturate != 0) fix_quot = res_neg ? -max_c[OutW-1:0] : max_c[OutW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      num_neg     <= 1'b0;
      den_neg     <= 1'b0;
      den_zero    <= 1'b0;
      dvd         <= '0;
      q           <= '0;
      dmag        <= '0;
      rem         <= '0;
      out_valid   <= 1'b0;
      quot        <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            num_neg  <= num_sign;
            den_neg  <= den_sign;
            den_zero <= (den == '0);
            dvd      <= dvd_load;
            dmag     <= den_mag;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          rem <= borrow ? rem_sh : trial[DenW:0];
          q   <= {q[IterN-2:0], ~borrow};
          if (cnt == CntW'(IterN - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          quot        <= fix_quot;
          div_by_zero <= den_zero;
          overflow    <= fix_ovf;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
